// File: rtl/rob_commit_ctrl_pkg.sv
// Shared types and defaults for the ROB commit controller.
// Commit-type codes match the ROB head type field; FSM states are an enum.
package rob_commit_ctrl_pkg;

  localparam int DEF_ROB_WIDTH  = 4;
  localparam int DEF_REG_WIDTH  = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FLUSH_HOLD = 2;
  localparam int CNT_WIDTH      = 32;

  localparam logic [1:0] CMT_REG    = 2'd0;
  localparam logic [1:0] CMT_STORE  = 2'd1;
  localparam logic [1:0] CMT_BRANCH = 2'd2;

  typedef enum logic [1:0] {
    CC_RUN        = 2'd0,
    CC_STORE_WAIT = 2'd1,
    CC_FLUSH      = 2'd2
  } cc_state_e;

  // Anything that is not a store retires in a single cycle.
  function automatic logic is_single_cycle(input logic [1:0] cmt_type);
    return cmt_type != CMT_STORE;
  endfunction

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Bundle of ROB head, RegFile, LSB and fetch signals around the commit controller.
// master = commit controller side, slave = the surrounding pipeline.
interface rob_commit_ctrl_if
  import rob_commit_ctrl_pkg::*;
#(
  parameter int ROB_WIDTH  = DEF_ROB_WIDTH,
  parameter int REG_WIDTH  = DEF_REG_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  head_valid_rob_in;
  logic                  head_ready_rob_in;
  logic [1:0]            head_type_rob_in;
  logic [REG_WIDTH-1:0]  head_dest_rob_in;
  logic [DATA_WIDTH-1:0] head_value_rob_in;
  logic [ROB_WIDTH-1:0]  head_id_rob_in;
  logic                  head_mispred_rob_in;
  logic [DATA_WIDTH-1:0] head_target_rob_in;
  logic                  pop_rob_out;
  logic                  rdy_commit_rf_out;
  logic [REG_WIDTH-1:0]  dest_rf_out;
  logic [DATA_WIDTH-1:0] value_rf_out;
  logic [ROB_WIDTH-1:0]  rob_id_rf_out;
  logic                  store_req_lsb_out;
  logic [ROB_WIDTH-1:0]  store_id_lsb_out;
  logic                  store_done_lsb_in;
  logic                  refresh_out;
  logic                  redirect_out;
  logic [DATA_WIDTH-1:0] target_out;
  logic [CNT_WIDTH-1:0]  retired_cnt_out;

  modport master (
    input  head_valid_rob_in, head_ready_rob_in, head_type_rob_in, head_dest_rob_in,
           head_value_rob_in, head_id_rob_in, head_mispred_rob_in, head_target_rob_in,
           store_done_lsb_in,
    output pop_rob_out, rdy_commit_rf_out, dest_rf_out, value_rf_out, rob_id_rf_out,
           store_req_lsb_out, store_id_lsb_out, refresh_out, redirect_out, target_out,
           retired_cnt_out
  );

  modport slave (
    output head_valid_rob_in, head_ready_rob_in, head_type_rob_in, head_dest_rob_in,
           head_value_rob_in, head_id_rob_in, head_mispred_rob_in, head_target_rob_in,
           store_done_lsb_in,
    input  pop_rob_out, rdy_commit_rf_out, dest_rf_out, value_rf_out, rob_id_rf_out,
           store_req_lsb_out, store_id_lsb_out, refresh_out, redirect_out, target_out,
           retired_cnt_out
  );
endinterface

// File: rtl/rob_commit_ctrl_flush_timer.sv
// Down-counter that sets how long refresh stays asserted after a mispredict.
// Loaded with HOLD-1; o_done is high once the count has reached zero.
module rob_commit_ctrl_flush_timer #(
  parameter int HOLD = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic i_load,
  input  logic i_count,
  output logic o_done
);
  localparam int TW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [TW-1:0] LOAD_VAL = TW'(HOLD - 1);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VAL;
    end else if (i_count && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);
endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order retirement sequencer: retires the ROB head into the RegFile, hands
// stores to the LSB and waits, or flushes the machine on a mispredicted branch.
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
#(
  parameter int ROB_WIDTH  = DEF_ROB_WIDTH,
  parameter int REG_WIDTH  = DEF_REG_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FLUSH_HOLD = DEF_FLUSH_HOLD
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  rob_commit_ctrl_if.master bus
);
  cc_state_e             r_state, w_state_next;
  logic                  r_rdy_commit, w_rdy_commit_next;
  logic [REG_WIDTH-1:0]  r_dest, w_dest_next;
  logic [DATA_WIDTH-1:0] r_value, w_value_next;
  logic [ROB_WIDTH-1:0]  r_rob_id, w_rob_id_next;
  logic                  r_store_req, w_store_req_next;
  logic [ROB_WIDTH-1:0]  r_store_id, w_store_id_next;
  logic                  r_refresh, w_refresh_next;
  logic                  r_redirect, w_redirect_next;
  logic [DATA_WIDTH-1:0] r_target, w_target_next;
  logic                  r_flush_arm, w_flush_arm_next;
  logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_next;
  logic                  w_acc, w_pop;
  logic                  w_timer_load, w_timer_count, w_timer_done;

  rob_commit_ctrl_flush_timer #(.HOLD(FLUSH_HOLD)) u_flush_timer (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .i_load  (w_timer_load),
    .i_count (w_timer_count),
    .o_done  (w_timer_done)
  );

  assign w_acc = rdy_in && (r_state == CC_RUN) && bus.head_valid_rob_in && bus.head_ready_rob_in;

  always_comb begin
    w_state_next      = r_state;
    w_rdy_commit_next = 1'b0;
    w_dest_next       = r_dest;
    w_value_next      = r_value;
    w_rob_id_next     = r_rob_id;
    w_store_req_next  = r_store_req;
    w_store_id_next   = r_store_id;
    w_refresh_next    = r_refresh;
    w_redirect_next   = 1'b0;
    w_target_next     = r_target;
    w_flush_arm_next  = r_flush_arm;
    w_cnt_next        = r_cnt;
    w_pop             = 1'b0;
    w_timer_load      = 1'b0;
    w_timer_count     = 1'b0;
    if (rdy_in) begin
      case (r_state)
        CC_RUN: begin
          if (w_acc && !is_single_cycle(bus.head_type_rob_in)) begin
            w_store_req_next = 1'b1;
            w_store_id_next  = bus.head_id_rob_in;
            w_state_next     = CC_STORE_WAIT;
          end else if (w_acc) begin
            w_pop             = 1'b1;
            w_rdy_commit_next = (bus.head_dest_rob_in != '0);
            w_dest_next       = bus.head_dest_rob_in;
            w_value_next      = bus.head_value_rob_in;
            w_rob_id_next     = bus.head_id_rob_in;
            w_cnt_next        = r_cnt + 1'b1;
            // Refresh is deferred one edge so it never overlaps the link-write strobe.
            if ((bus.head_type_rob_in == CMT_BRANCH) && bus.head_mispred_rob_in) begin
              w_target_next    = bus.head_target_rob_in;
              w_flush_arm_next = 1'b1;
              w_state_next     = CC_FLUSH;
            end
          end
        end
        CC_STORE_WAIT: begin
          if (bus.store_done_lsb_in) begin
            w_pop            = 1'b1;
            w_store_req_next = 1'b0;
            w_cnt_next       = r_cnt + 1'b1;
            w_state_next     = CC_RUN;
          end
        end
        CC_FLUSH: begin
          if (r_flush_arm) begin
            w_refresh_next   = 1'b1;
            w_redirect_next  = 1'b1;
            w_flush_arm_next = 1'b0;
            w_timer_load     = 1'b1;
          end else if (w_timer_done) begin
            w_refresh_next = 1'b0;
            w_state_next   = CC_RUN;
          end else begin
            w_timer_count = 1'b1;
          end
        end
        default: w_state_next = CC_RUN;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= CC_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_rdy_commit <= 1'b0;
      r_dest       <= '0;
      r_value      <= '0;
      r_rob_id     <= '0;
      r_store_req  <= 1'b0;
      r_store_id   <= '0;
      r_refresh    <= 1'b0;
      r_redirect   <= 1'b0;
      r_target     <= '0;
      r_flush_arm  <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_rdy_commit <= w_rdy_commit_next;
      r_dest       <= w_dest_next;
      r_value      <= w_value_next;
      r_rob_id     <= w_rob_id_next;
      r_store_req  <= w_store_req_next;
      r_store_id   <= w_store_id_next;
      r_refresh    <= w_refresh_next;
      r_redirect   <= w_redirect_next;
      r_target     <= w_target_next;
      r_flush_arm  <= w_flush_arm_next;
      r_cnt        <= w_cnt_next;
    end
  end

  assign bus.pop_rob_out       = w_pop;
  assign bus.rdy_commit_rf_out = r_rdy_commit;
  assign bus.dest_rf_out       = r_dest;
  assign bus.value_rf_out      = r_value;
  assign bus.rob_id_rf_out     = r_rob_id;
  assign bus.store_req_lsb_out = r_store_req;
  assign bus.store_id_lsb_out  = r_store_id;
  assign bus.refresh_out       = r_refresh;
  assign bus.redirect_out      = r_redirect;
  assign bus.target_out        = r_target;
  assign bus.retired_cnt_out   = r_cnt;
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl: reset, back-to-back retire, store wait,
// mispredict flush, rdy_in freeze, reset mid-store and late-ready head.
module tb_rob_commit_ctrl;
  import rob_commit_ctrl_pkg::*;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  int   total = 0;
  int   bad   = 0;

  rob_commit_ctrl_if bus ();

  rob_commit_ctrl #(.FLUSH_HOLD(2)) u_dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus.master)
  );

  always #5 clk_in = ~clk_in;

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_head(input logic v, input logic r, input logic [1:0] t,
                          input logic [4:0] d, input logic [31:0] val,
                          input logic [3:0] id, input logic m, input logic [31:0] tgt);
    bus.head_valid_rob_in   = v;
    bus.head_ready_rob_in   = r;
    bus.head_type_rob_in    = t;
    bus.head_dest_rob_in    = d;
    bus.head_value_rob_in   = val;
    bus.head_id_rob_in      = id;
    bus.head_mispred_rob_in = m;
    bus.head_target_rob_in  = tgt;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    bus.store_done_lsb_in = 1'b0;
    set_head(1'b0, 1'b0, CMT_REG, 5'd0, 32'h0, 4'd0, 1'b0, 32'h0);
    #12;
    total++; if (bus.pop_rob_out !== 1'b0) begin bad++; $display("FAIL rst_pop got=%b want=0", bus.pop_rob_out); end
    total++; if (bus.rdy_commit_rf_out !== 1'b0) begin bad++; $display("FAIL rst_commit got=%b want=0", bus.rdy_commit_rf_out); end
    total++; if (bus.store_req_lsb_out !== 1'b0) begin bad++; $display("FAIL rst_store_req got=%b want=0", bus.store_req_lsb_out); end
    total++; if ({bus.refresh_out, bus.redirect_out} !== 2'b00) begin bad++; $display("FAIL rst_flush got=%b want=00", {bus.refresh_out, bus.redirect_out}); end
    total++; if (bus.retired_cnt_out !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", bus.retired_cnt_out); end
    total++; if (bus.target_out !== 32'd0) begin bad++; $display("FAIL rst_target got=%h want=0", bus.target_out); end
    cyc();
    rst_in = 1'b0;
    cyc();
    $display("reset: cnt=%0d", bus.retired_cnt_out);
  endtask

  task automatic test_back_to_back();
    set_head(1'b1, 1'b1, CMT_REG, 5'd5, 32'h11, 4'd1, 1'b0, 32'h0);
    #1;
    total++; if (bus.pop_rob_out !== 1'b1) begin bad++; $display("FAIL b2b_pop_x5 got=%b want=1", bus.pop_rob_out); end
    cyc();
    total++; if (bus.rdy_commit_rf_out !== 1'b1) begin bad++; $display("FAIL b2b_commit_x5 got=%b want=1", bus.rdy_commit_rf_out); end
    total++; if ({bus.dest_rf_out, bus.value_rf_out, bus.rob_id_rf_out} !== {5'd5, 32'h11, 4'd1}) begin
      bad++; $display("FAIL b2b_data_x5 got=%0d/%h/%0d want=5/11/1", bus.dest_rf_out, bus.value_rf_out, bus.rob_id_rf_out); end
    $display("b2b: x5 commit=%b cnt=%0d", bus.rdy_commit_rf_out, bus.retired_cnt_out);
    set_head(1'b1, 1'b1, CMT_REG, 5'd6, 32'h22, 4'd2, 1'b0, 32'h0);
    #1;
    total++; if (bus.pop_rob_out !== 1'b1) begin bad++; $display("FAIL b2b_pop_x6 got=%b want=1", bus.pop_rob_out); end
    cyc();
    total++; if ({bus.rdy_commit_rf_out, bus.dest_rf_out, bus.value_rf_out} !== {1'b1, 5'd6, 32'h22}) begin
      bad++; $display("FAIL b2b_commit_x6 got=%b/%0d/%h want=1/6/22", bus.rdy_commit_rf_out, bus.dest_rf_out, bus.value_rf_out); end
    $display("b2b: x6 commit=%b cnt=%0d", bus.rdy_commit_rf_out, bus.retired_cnt_out);
    set_head(1'b1, 1'b1, CMT_REG, 5'd0, 32'h33, 4'd3, 1'b0, 32'h0);
    #1;
    total++; if (bus.pop_rob_out !== 1'b1) begin bad++; $display("FAIL b2b_pop_x0 got=%b want=1", bus.pop_rob_out); end
    cyc();
    total++; if (bus.rdy_commit_rf_out !== 1'b0) begin bad++; $display("FAIL b2b_commit_x0 got=%b want=0", bus.rdy_commit_rf_out); end
    total++; if (bus.retired_cnt_out !== 32'd3) begin bad++; $display("FAIL b2b_cnt got=%0d want=3", bus.retired_cnt_out); end
    $display("b2b: x0 commit=%b cnt=%0d", bus.rdy_commit_rf_out, bus.retired_cnt_out);
    set_head(1'b0, 1'b0, CMT_REG, 5'd0, 32'h0, 4'd0, 1'b0, 32'h0);
    #1;
    total++; if (bus.pop_rob_out !== 1'b0) begin bad++; $display("FAIL b2b_pop_empty got=%b want=0", bus.pop_rob_out); end
    cyc();
  endtask

  task automatic test_store();
    set_head(1'b1, 1'b1, CMT_STORE, 5'd0, 32'h0, 4'd4, 1'b0, 32'h0);
    #1;
    total++; if (bus.pop_rob_out !== 1'b0) begin bad++; $display("FAIL st_pop_accept got=%b want=0", bus.pop_rob_out); end
    cyc();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.store_done_lsb_in = 1'b1;
      #1;
      total++; if ({bus.store_req_lsb_out, bus.store_id_lsb_out} !== {1'b1, 4'd4}) begin
        bad++; $display("FAIL st_req_c%0d got=%b/%0d want=1/4", i, bus.store_req_lsb_out, bus.store_id_lsb_out); end
      total++; if (bus.pop_rob_out !== (i == 2)) begin bad++; $display("FAIL st_pop_c%0d got=%b want=%b", i, bus.pop_rob_out, i == 2); end
      total++; if (bus.retired_cnt_out !== 32'd3) begin bad++; $display("FAIL st_cnt_c%0d got=%0d want=3", i, bus.retired_cnt_out); end
      $display("store: cycle %0d req=%b pop=%b", i, bus.store_req_lsb_out, bus.pop_rob_out);
      cyc();
    end
    bus.store_done_lsb_in = 1'b0;
    set_head(1'b0, 1'b0, CMT_REG, 5'd0, 32'h0, 4'd0, 1'b0, 32'h0);
    total++; if ({bus.store_req_lsb_out, bus.retired_cnt_out} !== {1'b0, 32'd4}) begin
      bad++; $display("FAIL st_done got=%b/%0d want=0/4", bus.store_req_lsb_out, bus.retired_cnt_out); end
    bus.store_done_lsb_in = 1'b1;
    #1;
    total++; if (bus.pop_rob_out !== 1'b0) begin bad++; $display("FAIL st_stray_pop got=%b want=0", bus.pop_rob_out); end
    cyc();
    bus.store_done_lsb_in = 1'b0;
    total++; if (bus.retired_cnt_out !== 32'd4) begin bad++; $display("FAIL st_stray_cnt got=%0d want=4", bus.retired_cnt_out); end
    $display("store: done cnt=%0d", bus.retired_cnt_out);
  endtask

  task automatic test_mispredict();
    set_head(1'b1, 1'b1, CMT_BRANCH, 5'd1, 32'h104, 4'd5, 1'b1, 32'h200);
    #1;
    total++; if (bus.pop_rob_out !== 1'b1) begin bad++; $display("FAIL mp_pop got=%b want=1", bus.pop_rob_out); end
    cyc();
    total++; if ({bus.rdy_commit_rf_out, bus.dest_rf_out, bus.value_rf_out} !== {1'b1, 5'd1, 32'h104}) begin
      bad++; $display("FAIL mp_link got=%b/%0d/%h want=1/1/104", bus.rdy_commit_rf_out, bus.dest_rf_out, bus.value_rf_out); end
    total++; if ({bus.refresh_out, bus.redirect_out} !== 2'b00) begin bad++; $display("FAIL mp_early_refresh got=%b want=00", {bus.refresh_out, bus.redirect_out}); end
    total++; if (bus.retired_cnt_out !== 32'd5) begin bad++; $display("FAIL mp_cnt got=%0d want=5", bus.retired_cnt_out); end
    $display("mispredict: link commit=%b cnt=%0d", bus.rdy_commit_rf_out, bus.retired_cnt_out);
    set_head(1'b1, 1'b1, CMT_REG, 5'd7, 32'h77, 4'd6, 1'b0, 32'h0);
    #1;
    total++; if (bus.pop_rob_out !== 1'b0) begin bad++; $display("FAIL mp_pop_arm got=%b want=0", bus.pop_rob_out); end
    cyc();
    total++; if ({bus.refresh_out, bus.redirect_out, bus.rdy_commit_rf_out} !== 3'b110) begin
      bad++; $display("FAIL mp_flush1 got=%b want=110", {bus.refresh_out, bus.redirect_out, bus.rdy_commit_rf_out}); end
    total++; if (bus.target_out !== 32'h200) begin bad++; $display("FAIL mp_target got=%h want=200", bus.target_out); end
    #1;
    total++; if (bus.pop_rob_out !== 1'b0) begin bad++; $display("FAIL mp_pop_f1 got=%b want=0", bus.pop_rob_out); end
    $display("mispredict: refresh=1 redirect=1 target=%h", bus.target_out);
    cyc();
    total++; if ({bus.refresh_out, bus.redirect_out} !== 2'b10) begin bad++; $display("FAIL mp_flush2 got=%b want=10", {bus.refresh_out, bus.redirect_out}); end
    #1;
    total++; if (bus.pop_rob_out !== 1'b0) begin bad++; $display("FAIL mp_pop_f2 got=%b want=0", bus.pop_rob_out); end
    cyc();
    total++; if (bus.refresh_out !== 1'b0) begin bad++; $display("FAIL mp_refresh_end got=%b want=0", bus.refresh_out); end
    #1;
    total++; if (bus.pop_rob_out !== 1'b1) begin bad++; $display("FAIL mp_pop_resume got=%b want=1", bus.pop_rob_out); end
    cyc();
    total++; if ({bus.rdy_commit_rf_out, bus.dest_rf_out, bus.retired_cnt_out} !== {1'b1, 5'd7, 32'd6}) begin
      bad++; $display("FAIL mp_after got=%b/%0d/%0d want=1/7/6", bus.rdy_commit_rf_out, bus.dest_rf_out, bus.retired_cnt_out); end
    $display("mispredict: resumed x7 cnt=%0d", bus.retired_cnt_out);
    set_head(1'b0, 1'b0, CMT_REG, 5'd0, 32'h0, 4'd0, 1'b0, 32'h0);
  endtask

  task automatic test_rdy_freeze();
    rdy_in = 1'b0;
    set_head(1'b1, 1'b1, CMT_REG, 5'd8, 32'h88, 4'd7, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (bus.pop_rob_out !== 1'b0) begin bad++; $display("FAIL frz_pop_c%0d got=%b want=0", i, bus.pop_rob_out); end
      cyc();
      total++; if ({bus.rdy_commit_rf_out, bus.retired_cnt_out} !== {1'b0, 32'd6}) begin
        bad++; $display("FAIL frz_hold_c%0d got=%b/%0d want=0/6", i, bus.rdy_commit_rf_out, bus.retired_cnt_out); end
      $display("freeze: cycle %0d commit=%b cnt=%0d", i, bus.rdy_commit_rf_out, bus.retired_cnt_out);
    end
    rdy_in = 1'b1;
    #1;
    total++; if (bus.pop_rob_out !== 1'b1) begin bad++; $display("FAIL frz_pop_resume got=%b want=1", bus.pop_rob_out); end
    cyc();
    total++; if ({bus.rdy_commit_rf_out, bus.dest_rf_out, bus.value_rf_out, bus.rob_id_rf_out, bus.retired_cnt_out} !==
                 {1'b1, 5'd8, 32'h88, 4'd7, 32'd7}) begin
      bad++; $display("FAIL frz_commit got=%b/%0d/%h/%0d/%0d want=1/8/88/7/7", bus.rdy_commit_rf_out, bus.dest_rf_out,
                      bus.value_rf_out, bus.rob_id_rf_out, bus.retired_cnt_out); end
    $display("freeze: resumed x8 cnt=%0d", bus.retired_cnt_out);
    set_head(1'b0, 1'b0, CMT_REG, 5'd0, 32'h0, 4'd0, 1'b0, 32'h0);
  endtask

  task automatic test_reset_store_wait();
    set_head(1'b1, 1'b1, CMT_STORE, 5'd0, 32'h0, 4'd9, 1'b0, 32'h0);
    cyc();
    total++; if ({bus.store_req_lsb_out, bus.store_id_lsb_out} !== {1'b1, 4'd9}) begin
      bad++; $display("FAIL rsw_req got=%b/%0d want=1/9", bus.store_req_lsb_out, bus.store_id_lsb_out); end
    #2;
    rst_in = 1'b1;
    #1;
    total++; if ({bus.store_req_lsb_out, bus.store_id_lsb_out} !== {1'b0, 4'd0}) begin
      bad++; $display("FAIL rsw_async_req got=%b/%0d want=0/0", bus.store_req_lsb_out, bus.store_id_lsb_out); end
    total++; if (bus.retired_cnt_out !== 32'd0) begin bad++; $display("FAIL rsw_cnt got=%0d want=0", bus.retired_cnt_out); end
    $display("reset mid-store: req=%b cnt=%0d", bus.store_req_lsb_out, bus.retired_cnt_out);
    set_head(1'b0, 1'b0, CMT_REG, 5'd0, 32'h0, 4'd0, 1'b0, 32'h0);
    cyc();
    rst_in = 1'b0;
    set_head(1'b1, 1'b1, CMT_REG, 5'd9, 32'h99, 4'd10, 1'b0, 32'h0);
    #1;
    total++; if (bus.pop_rob_out !== 1'b1) begin bad++; $display("FAIL rsw_run_pop got=%b want=1", bus.pop_rob_out); end
    cyc();
    total++; if ({bus.rdy_commit_rf_out, bus.dest_rf_out, bus.retired_cnt_out} !== {1'b1, 5'd9, 32'd1}) begin
      bad++; $display("FAIL rsw_run_commit got=%b/%0d/%0d want=1/9/1", bus.rdy_commit_rf_out, bus.dest_rf_out, bus.retired_cnt_out); end
    set_head(1'b0, 1'b0, CMT_REG, 5'd0, 32'h0, 4'd0, 1'b0, 32'h0);
  endtask

  task automatic test_not_ready();
    set_head(1'b1, 1'b0, CMT_REG, 5'd10, 32'hAA, 4'd11, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (bus.pop_rob_out !== 1'b0) begin bad++; $display("FAIL nr_pop_c%0d got=%b want=0", i, bus.pop_rob_out); end
      cyc();
      total++; if (bus.rdy_commit_rf_out !== 1'b0) begin bad++; $display("FAIL nr_commit_c%0d got=%b want=0", i, bus.rdy_commit_rf_out); end
      $display("not-ready: cycle %0d pop=0 cnt=%0d", i, bus.retired_cnt_out);
    end
    bus.head_ready_rob_in = 1'b1;
    #1;
    total++; if (bus.pop_rob_out !== 1'b1) begin bad++; $display("FAIL nr_pop_ready got=%b want=1", bus.pop_rob_out); end
    cyc();
    set_head(1'b0, 1'b0, CMT_REG, 5'd0, 32'h0, 4'd0, 1'b0, 32'h0);
    total++; if ({bus.rdy_commit_rf_out, bus.dest_rf_out, bus.value_rf_out, bus.retired_cnt_out} !== {1'b1, 5'd10, 32'hAA, 32'd2}) begin
      bad++; $display("FAIL nr_commit got=%b/%0d/%h/%0d want=1/10/aa/2", bus.rdy_commit_rf_out, bus.dest_rf_out,
                      bus.value_rf_out, bus.retired_cnt_out); end
    #1;
    total++; if (bus.pop_rob_out !== 1'b0) begin bad++; $display("FAIL nr_single_pop got=%b want=0", bus.pop_rob_out); end
    cyc();
    total++; if ({bus.rdy_commit_rf_out, bus.retired_cnt_out} !== {1'b0, 32'd2}) begin
      bad++; $display("FAIL nr_after got=%b/%0d want=0/2", bus.rdy_commit_rf_out, bus.retired_cnt_out); end
    $display("not-ready: single retire cnt=%0d", bus.retired_cnt_out);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_store();
    test_mispredict();
    test_rdy_freeze();
    test_reset_store_wait();
    test_not_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
